// File: rtl/soc_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | soc_mem_responder_pkg                                                      |
// | Shared state encoding and default configuration for the memory responder.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package StaticPack;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    STORE_WAIT = 2'd2
  } memState_;
endpackage

package ConfigPack;
  localparam int MEM_DEPTH_WORDS   = 4096;
  localparam int MEM_LOAD_LATENCY  = 2;
  localparam int MEM_STORE_LATENCY = 1;
endpackage

`default_nettype wire

// File: rtl/soc_mem_responder_mem_array_2p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_array_2p                                                               |
// | Word array with a byte-enabled write/read port and a registered read port. |
// | Option: MEM_WRITE_FIRST_EN makes the read-only port see same-edge writes.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module mem_array_2p #(
  parameter int DEPTH_WORDS = 4096,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wrEn,
  input  logic [AW-1:0] dAddr,
  input  logic [31:0]   wrData,
  input  logic [3:0]    wrBe,
  output logic [31:0]   dRdData,
  input  logic [AW-1:0] iAddr,
  output logic [31:0]   iRdData
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] iRdNext;

  always_ff @(posedge clock) begin
    if (wrEn) begin
      for (int n = 0; n < 4; n++) begin
        if (wrBe[n]) mem[dAddr][8*n +: 8] <= wrData[8*n +: 8];
      end
    end
  end

  assign dRdData = mem[dAddr];

`ifdef MEM_WRITE_FIRST_EN
  logic bypassHit;
  assign bypassHit = wrEn && (dAddr == iAddr);

  // Only the lanes being written take the new byte; the rest keep the stored value.
  for (genvar n = 0; n < 4; n++) begin : g_bypassLane
    assign iRdNext[8*n +: 8] = (bypassHit && wrBe[n]) ? wrData[8*n +: 8]
                                                      : mem[iAddr][8*n +: 8];
  end
`else
  assign iRdNext = mem[iAddr];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) iRdData <= '0;
    else       iRdData <= iRdNext;
  end

endmodule

`default_nettype wire

// File: rtl/soc_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | soc_mem_responder                                                          |
// | Fetch/data memory responder: one-cycle fetch port and a latency-counting   |
// | load/store port. Option: MEM_WRITE_FIRST_EN (fetch sees same-edge stores). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module soc_mem_responder
  import StaticPack::*;
  import ConfigPack::*;
#(
  parameter int DEPTH_WORDS   = MEM_DEPTH_WORDS,
  parameter int LOAD_LATENCY  = MEM_LOAD_LATENCY,
  parameter int STORE_LATENCY = MEM_STORE_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i_address,
  output logic [31:0] i_data,
  output logic        i_valid,
  input  logic [31:0] d_address,
  input  logic [31:0] storeData,
  input  logic [3:0]  byteEnable,
  input  logic        storeValid,
  input  logic        loadValid,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete
);

  localparam int AW      = $clog2(DEPTH_WORDS);
  localparam int MAX_LAT = (LOAD_LATENCY > STORE_LATENCY) ? LOAD_LATENCY : STORE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] LOAD_CNT  = CW'(LOAD_LATENCY - 1);
  localparam logic [CW-1:0] STORE_CNT = CW'(STORE_LATENCY - 1);

  memState_      state;
  logic [CW-1:0] count;
  logic [31:0]   holdQ;
  logic [31:0]   iAddrQ;
  logic          iValidQ;
  logic [31:0]   dRdData;
  logic          acceptStore;
  logic          acceptLoad;
  logic          loadDue;
  logic          storeDue;
  logic          unusedDAddr;

  assign unusedDAddr = ^{d_address[31:AW+2], d_address[1:0]};

  assign acceptStore = (state == IDLE) && storeValid;
  assign acceptLoad  = (state == IDLE) && !storeValid && loadValid;

  // The response cycle is the WAIT cycle with count==0; these flag the cycle before it.
  assign loadDue  = (acceptLoad && (LOAD_LATENCY == 1)) ||
                    ((state == LOAD_WAIT) && (count == CW'(1)));
  assign storeDue = (acceptStore && (STORE_LATENCY == 1)) ||
                    ((state == STORE_WAIT) && (count == CW'(1)));

  assign i_valid = iValidQ && (iAddrQ == i_address);

  mem_array_2p #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .wrEn   (acceptStore),
    .dAddr  (d_address[AW+1:2]),
    .wrData (storeData),
    .wrBe   (byteEnable),
    .dRdData(dRdData),
    .iAddr  (i_address[AW+1:2]),
    .iRdData(i_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      holdQ         <= '0;
      loadData      <= '0;
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;
      iAddrQ        <= '0;
      iValidQ       <= 1'b0;
    end else begin
      iValidQ       <= 1'b1;
      iAddrQ        <= i_address;
      loadDataValid <= loadDue;
      storeComplete <= storeDue;
      // With a one-cycle load the holding register is bypassed.
      if (loadDue) loadData <= (state == IDLE) ? dRdData : holdQ;
      case (state)
        IDLE: begin
          if (storeValid) begin
            count <= STORE_CNT;
            state <= STORE_WAIT;
          end else if (loadValid) begin
            holdQ <= dRdData;
            count <= LOAD_CNT;
            state <= LOAD_WAIT;
          end
        end
        LOAD_WAIT, STORE_WAIT: begin
          if (count != '0) count <= count - CW'(1);
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_soc_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_soc_mem_responder                                                       |
// | Directed and randomized checks of the memory responder against a model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_soc_mem_responder;

  localparam int DEPTH = 4096;
  localparam int LL    = 2;
  localparam int SL    = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address = '0;
  logic [31:0] i_data;
  logic        i_valid;
  logic [31:0] d_address = '0;
  logic [31:0] storeData = '0;
  logic [3:0]  byteEnable = '0;
  logic        storeValid = 1'b0;
  logic        loadValid = 1'b0;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] lastLoad = '0;

  always #5 clock = ~clock;

  soc_mem_responder #(
    .DEPTH_WORDS  (DEPTH),
    .LOAD_LATENCY (LL),
    .STORE_LATENCY(SL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_address    (i_address),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .d_address    (d_address),
    .storeData    (storeData),
    .byteEnable   (byteEnable),
    .storeValid   (storeValid),
    .loadValid    (loadValid),
    .loadData     (loadData),
    .loadDataValid(loadDataValid),
    .storeComplete(storeComplete)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int n = 0; n < 4; n++)
      if (be[n]) model[widx(a)][8*n +: 8] = d[8*n +: 8];
  endtask

  task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    d_address = a; storeData = d; byteEnable = be; storeValid = 1'b1;
    @(posedge clock); #1; n = 1;
    // Inputs must be ignored once the store has been accepted.
    d_address = $urandom; storeData = $urandom; byteEnable = 4'($urandom);
    while (!storeComplete && n < 20) begin @(posedge clock); #1; n++; end
    storeValid = 1'b0;
    modelWrite(a, d, be);
    chk("st_latency", 32'(n), 32'(SL));
    chk("st_no_load_pulse", {31'b0, loadDataValid}, 32'd0);
    @(posedge clock); #1;
    chk("st_single_pulse", {31'b0, storeComplete}, 32'd0);
  endtask

  task automatic doLoad(input logic [31:0] a);
    int n;
    logic [31:0] exp;
    exp = model[widx(a)];
    d_address = a; loadValid = 1'b1;
    @(posedge clock); #1; n = 1;
    d_address = $urandom;
    if (!loadDataValid) chk("ld_hold_prev", loadData, lastLoad);
    while (!loadDataValid && n < 20) begin @(posedge clock); #1; n++; end
    loadValid = 1'b0;
    chk("ld_latency", 32'(n), 32'(LL));
    chk("ld_data", loadData, exp);
    lastLoad = exp;
    @(posedge clock); #1;
    chk("ld_single_pulse", {31'b0, loadDataValid}, 32'd0);
    chk("ld_data_held", loadData, exp);
  endtask

  task automatic fetch(input logic [31:0] a);
    i_address = a;
    #1;
    chk("if_valid_on_change", {31'b0, i_valid}, 32'd0);
    @(posedge clock); #1;
    chk("if_valid_stable", {31'b0, i_valid}, 32'd1);
    chk("if_data", i_data, model[widx(a)]);
  endtask

  initial begin
    int n;
    logic [31:0] oldWord;
    logic [31:0] a;
    logic [31:0] expWf;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_i_valid", {31'b0, i_valid}, 32'd0);
    chk("rst_i_data", i_data, 32'd0);
    chk("rst_loadData", loadData, 32'd0);
    chk("rst_ldv", {31'b0, loadDataValid}, 32'd0);
    chk("rst_stc", {31'b0, storeComplete}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_i_valid", {31'b0, i_valid}, 32'd1);

    // Full-word store, then load back
    doStore(32'h100, 32'hDEADBEEF, 4'b1111);
    doLoad(32'h100);
    chk("full_word", lastLoad, 32'hDEADBEEF);

    // Byte-lane store and address wrap
    doStore(32'h100, 32'h0000AA00, 4'b0010);
    doLoad(32'h100);
    chk("byte_merge", lastLoad, 32'hDEADAAEF);
    doLoad(32'h4100);
    chk("addr_wrap", lastLoad, 32'hDEADAAEF);

    // Preload a small working set
    for (int k = 1; k < 16; k++) doStore(32'h100 + 32'(4*k), $urandom, 4'b1111);

    // Instruction port
    fetch(32'h100);
    chk("if_0x100", i_data, 32'hDEADAAEF);
    fetch(32'h104);

    // Store/load collision with the fetch port reading the same word
    @(posedge clock); #1;
    oldWord = model[widx(32'h104)];
    if (oldWord == 32'h12345678) oldWord = ~oldWord;
    model[widx(32'h104)] = oldWord;
    doStore(32'h104, oldWord, 4'b1111);
    i_address = 32'h104;
    @(posedge clock); #1;
    d_address = 32'h104; storeData = 32'h12345678; byteEnable = 4'b1111;
    storeValid = 1'b1; loadValid = 1'b1;
    @(posedge clock); #1;
`ifdef MEM_WRITE_FIRST_EN
    expWf = 32'h12345678;
`else
    expWf = oldWord;
`endif
    chk("wf_i_data", i_data, expWf);
    chk("arb_store_first", {31'b0, storeComplete}, 32'd1);
    chk("arb_no_load_yet", {31'b0, loadDataValid}, 32'd0);
    storeValid = 1'b0;
    modelWrite(32'h104, 32'h12345678, 4'b1111);
    n = 0;
    do begin @(posedge clock); #1; n++; if (n == 1) chk("wf_i_data_next", i_data, 32'h12345678); end
    while (!loadDataValid && n < 20);
    loadValid = 1'b0;
    chk("arb_load_latency", 32'(n), 32'(LL + 1));
    chk("arb_load_data", loadData, 32'h12345678);
    lastLoad = 32'h12345678;
    @(posedge clock); #1;

    // Reset during LOAD_WAIT, request still held across it
    d_address = 32'h100; loadValid = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_loadData", loadData, 32'd0);
    chk("mid_rst_ldv", {31'b0, loadDataValid}, 32'd0);
    chk("mid_rst_i_valid", {31'b0, i_valid}, 32'd0);
    chk("mid_rst_i_data", i_data, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      chk("in_rst_no_pulse", {31'b0, loadDataValid}, 32'd0);
    end
    reset = 1'b0;
    lastLoad = '0;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!loadDataValid && n < 20);
    loadValid = 1'b0;
    chk("rst_reaccept_latency", 32'(n), 32'(LL));
    chk("rst_reaccept_data", loadData, 32'hDEADAAEF);
    lastLoad = 32'hDEADAAEF;
    @(posedge clock); #1;

    // Randomized traffic over the working set, with wrapped/unaligned addresses
    for (int k = 0; k < 60; k++) begin
      a = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(16'h40, 16'h4F)) << 2);
      case ($urandom_range(0, 2))
        0: doStore(a, $urandom, 4'($urandom));
        1: doLoad(a);
        default: begin
          if (a == i_address) a = a ^ 32'h8000_0000;
          fetch(a);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
